// File: rtl/fence_t_sequencer.sv
// Multi-channel fence.t microreset sequencer: flush every cache channel, wait for
// the memory side to drain, pad to a selectable timing event, then pulse a uarch clear.
module fence_t_sequencer #(
    parameter int unsigned NumCaches = 2,
    parameter int unsigned NumPadSrc = 2,
    parameter int unsigned PadWidth  = 32,
    parameter int unsigned DrainCyc  = 16,
    parameter int unsigned ClrCyc    = 16,
    parameter int unsigned InitHold  = 3,
    parameter int unsigned VLEN      = 64,
    parameter int unsigned SelW      = (NumPadSrc > 1) ? $clog2(NumPadSrc) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [VLEN-1:0]      boot_addr_i,
    input  logic                 fence_t_i,
    input  logic [VLEN-1:0]      pc_commit_i,
    input  logic [PadWidth-1:0]  pad_i,
    input  logic [SelW-1:0]      pad_src_sel_i,
    input  logic [NumPadSrc-1:0] pad_evt_i,
    output logic [NumCaches-1:0] flush_req_o,
    input  logic [NumCaches-1:0] flush_ack_i,
    input  logic [NumCaches-1:0] busy_i,
    output logic                 halt_o,
    output logic                 uarch_clr_o,
    output logic                 cache_init_no_o,
    output logic [VLEN-1:0]      rst_addr_o,
    output logic [PadWidth-1:0]  ceil_o,
    output logic [2:0]           state_o
);

    localparam int unsigned DW = $clog2(DrainCyc + 1);
    localparam int unsigned CW = $clog2(ClrCyc + 1);
    localparam int unsigned HW = (InitHold > 0) ? InitHold : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        DRAIN = 3'd2,
        PAD   = 3'd3,
        RST   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [NumCaches-1:0] ack_mask_q, ack_mask_d;
    logic [DW-1:0]        drain_cnt_q, drain_cnt_d, drain_nxt;
    logic [CW-1:0]        clr_cnt_q, clr_cnt_d;
    logic [PadWidth-1:0]  pad_cnt_q;
    logic [NumPadSrc-1:0] pad_evt_q;
    logic [VLEN-1:0]      rst_addr_q, rst_addr_d;
    logic [PadWidth-1:0]  ceil_q, ceil_d;
    logic [HW-1:0]        hold_sr_q;
    logic                 pad_rise;
    logic                 in_rst;

    // An out-of-range select disables the pad trigger entirely.
    always_comb begin
        pad_rise = 1'b0;
        if (32'(pad_src_sel_i) < NumPadSrc)
            pad_rise = pad_evt_i[pad_src_sel_i] & ~pad_evt_q[pad_src_sel_i];
    end

    always_comb begin
        drain_nxt = '0;
        if (!(|busy_i))
            drain_nxt = (drain_cnt_q == DW'(DrainCyc)) ? drain_cnt_q : drain_cnt_q + DW'(1);
    end

    always_comb begin
        state_d     = state_q;
        ack_mask_d  = ack_mask_q;
        drain_cnt_d = drain_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        rst_addr_d  = rst_addr_q;
        ceil_d      = ceil_q;
        flush_req_o = '0;
        uarch_clr_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (fence_t_i) begin
                    state_d    = FLUSH;
                    rst_addr_d = pc_commit_i + VLEN'(4);
                    ack_mask_d = '0;
                end
            end
            FLUSH: begin
                flush_req_o = ~ack_mask_q;
                ack_mask_d  = ack_mask_q | flush_ack_i;
                // Each drain window measures idle time from zero.
                if (&ack_mask_d) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_nxt;
                if (drain_nxt == DW'(DrainCyc)) begin
                    state_d = PAD;
                    ceil_d  = (pad_cnt_q == '0) ? '0 : pad_i - pad_cnt_q;
                end
            end
            PAD: begin
                if (pad_cnt_q == '0) state_d = RST;
            end
            RST: begin
                uarch_clr_o = 1'b1;
                if (clr_cnt_q == CW'(ClrCyc - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_rst = (state_q == RST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ack_mask_q  <= '0;
            drain_cnt_q <= '0;
            clr_cnt_q   <= '0;
            pad_cnt_q   <= '0;
            pad_evt_q   <= '0;
            rst_addr_q  <= boot_addr_i;
            ceil_q      <= '0;
            hold_sr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ack_mask_q  <= ack_mask_d;
            drain_cnt_q <= drain_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            rst_addr_q  <= rst_addr_d;
            ceil_q      <= ceil_d;
            pad_evt_q   <= pad_evt_i;
            // Pad counter free-runs in every state; a fresh event beats the decrement.
            if (pad_rise)
                pad_cnt_q <= pad_i;
            else if (pad_cnt_q != '0)
                pad_cnt_q <= pad_cnt_q - PadWidth'(1);
            hold_sr_q   <= ((hold_sr_q << 1) | HW'(in_rst)) & {HW{(InitHold > 0)}};
        end
    end

    assign halt_o          = (state_q != IDLE);
    assign cache_init_no_o = in_rst | (|hold_sr_q);
    assign rst_addr_o      = rst_addr_q;
    assign ceil_o          = ceil_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Randomized scoreboard bench: each planned fence.t sequence predicts its event timeline,
// a monitor measures the DUT timeline and compares when the sequence completes.
module tb_fence_t_sequencer;
    localparam int NC = 2, NP = 3, PW = 32, DC = 16, CC = 16, IH = 3, VL = 64, SW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [VL-1:0] boot_addr_i;
    logic          fence_t_i;
    logic [VL-1:0] pc_commit_i;
    logic [PW-1:0] pad_i;
    logic [SW-1:0] pad_src_sel_i;
    logic [NP-1:0] pad_evt_i;
    logic [NC-1:0] flush_req_o, flush_ack_i, busy_i;
    logic          halt_o, uarch_clr_o, cache_init_no_o;
    logic [VL-1:0] rst_addr_o;
    logic [PW-1:0] ceil_o;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    fence_t_sequencer #(.NumCaches(NC), .NumPadSrc(NP), .PadWidth(PW), .DrainCyc(DC),
                        .ClrCyc(CC), .InitHold(IH), .VLEN(VL)) dut (
        .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .fence_t_i(fence_t_i),
        .pc_commit_i(pc_commit_i), .pad_i(pad_i), .pad_src_sel_i(pad_src_sel_i),
        .pad_evt_i(pad_evt_i), .flush_req_o(flush_req_o), .flush_ack_i(flush_ack_i),
        .busy_i(busy_i), .halt_o(halt_o), .uarch_clr_o(uarch_clr_o),
        .cache_init_no_o(cache_init_no_o), .rst_addr_o(rst_addr_o), .ceil_o(ceil_o),
        .state_o(state_o)
    );

    typedef struct {
        int t_req0, t_req1, t_drain, t_pad, t_clr, t_idle, t_end;
        logic [VL-1:0] addr;
        logic [PW-1:0] ceil;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor: timeline relative to the fence.t cycle (the cycle before halt_o rises).
    initial begin : mon
        txn_t o, e;
        logic act;
        int   base, t;
        act = 1'b0;
        base = 0;
        forever begin
            @(negedge clk);
            if (!act && halt_o && !rst_i) begin
                act = 1'b1;
                base = cyc - 1;
                o.t_req0 = -1; o.t_req1 = -1; o.t_drain = -1; o.t_pad = -1;
                o.t_clr = -1; o.t_idle = -1; o.t_end = -1;
            end
            if (act) begin
                t = cyc - base;
                if (o.t_req0 < 0 && !flush_req_o[0]) o.t_req0 = t;
                if (o.t_req1 < 0 && !flush_req_o[1]) o.t_req1 = t;
                if (o.t_drain < 0 && state_o == 3'd2) o.t_drain = t;
                if (o.t_pad < 0 && state_o == 3'd3) o.t_pad = t;
                if (o.t_clr < 0 && uarch_clr_o) o.t_clr = t;
                if (o.t_idle < 0 && !halt_o) o.t_idle = t;
                if (!halt_o && !cache_init_no_o) begin
                    o.t_end = t; o.addr = rst_addr_o; o.ceil = ceil_o;
                    act = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_seq: got sequence ending at %0d expected none", t);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req0_drop", 64'(o.t_req0), 64'(e.t_req0));
                        chk("req1_drop", 64'(o.t_req1), 64'(e.t_req1));
                        chk("drain_entry", 64'(o.t_drain), 64'(e.t_drain));
                        chk("pad_entry", 64'(o.t_pad), 64'(e.t_pad));
                        chk("clr_start", 64'(o.t_clr), 64'(e.t_clr));
                        chk("halt_drop", 64'(o.t_idle), 64'(e.t_idle));
                        chk("init_drop", 64'(o.t_end), 64'(e.t_end));
                        chk("rst_addr", o.addr, e.addr);
                        chk("ceil", 64'(o.ceil), 64'(e.ceil));
                    end
                end
            end
        end
    end

    task automatic quiet();
        fence_t_i = 1'b0; pc_commit_i = '0; flush_ack_i = '0; busy_i = '0; pad_evt_i = '0;
    endtask

    // kind: 0 random, 1 basic, 2 same-cycle acks + busy restart, 3 pad ceiling,
    //       4 reset in PAD, 5 random reset
    task automatic run_seq(input int kind);
        int a0, a1, A, b, g, L, P0, X, e, Z, R0, ab, xf1, xf2, len, pc0, pz;
        logic glitch, ld, abort;
        logic [PW-1:0] padv;
        logic [1:0] sel;
        logic [VL-1:0] pc, boot;
        txn_t ex;

        a0 = $urandom_range(1, 8); a1 = $urandom_range(1, 8);
        b = $urandom_range(0, 5); glitch = 1'($urandom_range(0, 1)); g = $urandom_range(1, DC - 2);
        padv = PW'($urandom_range(0, 60)); sel = 2'($urandom_range(0, 3));
        if (kind == 1) begin a0 = 3; a1 = 7; b = 0; glitch = 1'b0; padv = '0; end
        if (kind == 2) begin a1 = a0; b = 0; glitch = 1'b1; g = 10; end
        if (kind == 3) begin b = 30; glitch = 1'b0; padv = 100; sel = 2'd0; end
        if (kind == 4) begin padv = 50; sel = 2'd1; end
        A = imax(a0, a1);
        L = glitch ? A + b + 1 + g : A + b;
        P0 = L + 1 + DC;
        X = P0 - 1;
        e = $urandom_range(1, X + 4);
        if (kind == 3) e = X - 41;
        if (kind == 4) e = X - 5;
        ld = (sel < NP);

        // pad count seen in cycle c: loaded at the edge ending cycle e, then counts down
        pc0 = (ld && e < X) ? imax(0, int'(padv) - (X - e - 1)) : 0;
        pz  = (ld && e < P0) ? imax(0, int'(padv) - (P0 - e - 1)) : 0;
        Z = (pz > 0) ? e + 1 + int'(padv) : P0;
        R0 = Z + 1;

        abort = (kind == 4) || (kind == 5);
        ab = (kind == 4) ? P0 + $urandom_range(0, Z - P0) : $urandom_range(1, R0 + CC - 1);
        xf1 = $urandom_range(1, A);
        xf2 = $urandom_range(R0, R0 + CC - 1);

        pc = {$urandom, $urandom};
        if ($urandom_range(0, 5) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC + 64'($urandom_range(0, 3));
        if (kind == 1) pc = 64'h1000;
        boot = {$urandom, $urandom};

        ex.t_req0 = a0 + 1; ex.t_req1 = a1 + 1; ex.t_drain = A + 1; ex.t_pad = P0;
        ex.t_clr = R0; ex.t_idle = R0 + CC; ex.t_end = R0 + CC + IH;
        ex.addr = pc + 64'd4;
        ex.ceil = (pc0 == 0) ? '0 : padv - PW'(pc0);
        if (abort) begin
            if (ex.t_req0 > ab + 1) ex.t_req0 = ab + 1;
            if (ex.t_req1 > ab + 1) ex.t_req1 = ab + 1;
            if (ex.t_drain > ab) ex.t_drain = -1;
            if (ex.t_pad > ab) ex.t_pad = -1;
            if (ex.t_clr > ab) ex.t_clr = -1;
            ex.t_idle = ab + 1; ex.t_end = ab + 1;
            ex.addr = boot; ex.ceil = '0;
        end
        exp_q.push_back(ex);

        len = abort ? ab : R0 + CC + IH + 1;
        boot_addr_i = boot; pad_i = padv; pad_src_sel_i = sel;
        for (int c = 0; c <= len; c++) begin
            fence_t_i = (c == 0) || ((c == xf1 || c == xf2) && (!abort || c < ab));
            pc_commit_i = (c == 0) ? pc : {$urandom, $urandom};
            flush_ack_i = {1'(c == a1), 1'(c == a0)};
            busy_i = ((c >= A + 1 && c <= A + b) || (glitch && c == A + b + 1 + g)) ?
                     NC'($urandom_range(1, 3)) : '0;
            for (int j = 0; j < NP; j++)
                pad_evt_i[j] = (j == int'(sel)) ? 1'(c >= e) : 1'($urandom_range(0, 1));
            rst_i = abort && (c == ab);
            @(posedge clk); #1;
        end
        quiet();
        for (int w = 0; w < 400 && exp_q.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL seq_timeout: got %0d pending expected 0", exp_q.size());
        end
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
    endtask

    initial begin
        rst_i = 1'b1; boot_addr_i = 64'h8000_0000; pad_i = '0; pad_src_sel_i = '0;
        quiet();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_halt", 64'(halt_o), 64'd0);
        chk("rst_clr", 64'(uarch_clr_o), 64'd0);
        chk("rst_init", 64'(cache_init_no_o), 64'd0);
        chk("rst_req", 64'(flush_req_o), 64'd0);
        chk("rst_ceil", 64'(ceil_o), 64'd0);
        chk("rst_addr0", rst_addr_o, 64'h8000_0000);
        @(posedge clk); #1 rst_i = 1'b0;
        @(posedge clk); #1;
        run_seq(1);
        run_seq(2);
        run_seq(3);
        run_seq(4);
        for (int s = 0; s < 26; s++) run_seq(($urandom_range(0, 3) == 0) ? 5 : 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
